// File: rtl/timer_display_pkg.sv
// Shared types and constants for the MM:SS timer display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_display_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } digits_t;

    // Active-low segments, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [6:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One double-dabble iteration on {tens, ones, 6-bit binary}.
    function automatic logic [13:0] dd_step(input logic [13:0] sr);
        logic [13:0] t;
        t = sr;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/timer_display_seven_seg_decoder.sv
// Purpose: one BCD digit plus blank flag to active-low seven-segment code.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module seven_seg_decoder
    import timer_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_dat,
    input  logic               blank,
    output logic [6:0]         seg_dat
);

    always_comb begin
        seg_dat = SEG_BLANK;
        if (!blank) seg_dat = seg_encode(digit_dat);
    end

endmodule

// File: rtl/timer_display.sv
// Purpose: sequential BCD conversion of min/sec and MM:SS seven-segment drive with expiry blink.
// Latency: inputs captured at edge k appear on hex after edge k+7; busy high after edges k..k+6.
// Backpressure: input changes during a conversion are not taken; the held-copy mismatch restarts it.
module timer_display
    import timer_display_pkg::*;
#(
    parameter int CLK_F           = 50000000,
    parameter int BLINK_HZ        = 2,
    parameter bit BLANK_LEAD_ZERO = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic       timer_end,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       busy
);

    localparam int HALF  = CLK_F / (2 * BLINK_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    state_t          state_q, state_d;
    logic [2:0]      iter_q, iter_d;
    logic [13:0]     sec_sr_q, sec_sr_d;
    logic [13:0]     min_sr_q, min_sr_d;
    logic [11:0]     hold_q, hold_d;
    digits_t         digits_q, digits_d;
    logic            disp_vld_q, disp_vld_d;
    logic            busy_q, busy_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_blank_q, blink_blank_d;

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        sec_sr_d   = sec_sr_q;
        min_sr_d   = min_sr_q;
        hold_d     = hold_q;
        digits_d   = digits_q;
        disp_vld_d = disp_vld_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (!disp_vld_q || ({min_in, sec_in} != hold_q)) begin
                    hold_d   = {min_in, sec_in};
                    sec_sr_d = {8'd0, sec_in};
                    min_sr_d = {8'd0, min_in};
                    iter_d   = 3'd0;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sec_sr_d = dd_step(sec_sr_q);
                min_sr_d = dd_step(min_sr_q);
                iter_d   = iter_q + 3'd1;
                if (iter_q == 3'd5) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                digits_d.min_tens = min_sr_q[13:10];
                digits_d.min_ones = min_sr_q[9:6];
                digits_d.sec_tens = sec_sr_q[13:10];
                digits_d.sec_ones = sec_sr_q[9:6];
                disp_vld_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Blink runs off timer_end alone so it can never stall a display update.
    always_comb begin
        blink_cnt_d   = '0;
        blink_blank_d = 1'b0;
        if (timer_end) begin
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d   = '0;
                blink_blank_d = !blink_blank_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + CNT_W'(1);
                blink_blank_d = blink_blank_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            iter_q        <= 3'd0;
            sec_sr_q      <= '0;
            min_sr_q      <= '0;
            hold_q        <= '0;
            digits_q      <= '0;
            disp_vld_q    <= 1'b0;
            busy_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_blank_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            sec_sr_q      <= sec_sr_d;
            min_sr_q      <= min_sr_d;
            hold_q        <= hold_d;
            digits_q      <= digits_d;
            disp_vld_q    <= disp_vld_d;
            busy_q        <= busy_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_blank_q <= blink_blank_d;
        end
    end

    logic blank_all;
    logic blank_lead;

    assign blank_all  = !disp_vld_q || blink_blank_q;
    assign blank_lead = blank_all || (BLANK_LEAD_ZERO && (digits_q.min_tens == 4'd0));
    assign busy       = busy_q;

    seven_seg_decoder u_dec0 (.digit_dat(digits_q.sec_ones), .blank(blank_all),  .seg_dat(hex0));
    seven_seg_decoder u_dec1 (.digit_dat(digits_q.sec_tens), .blank(blank_all),  .seg_dat(hex1));
    seven_seg_decoder u_dec2 (.digit_dat(digits_q.min_ones), .blank(blank_all),  .seg_dat(hex2));
    seven_seg_decoder u_dec3 (.digit_dat(digits_q.min_tens), .blank(blank_lead), .seg_dat(hex3));

endmodule

// File: tb/tb_timer_display.sv
// Purpose: directed checks of conversion latency, blanking, blink timing and reset abort.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_timer_display;

    localparam logic [6:0] B  = 7'h7F;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;

    logic       clock;
    logic       reset_n;
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic       timer_end;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       busy;

    int chk_cnt;
    int pass_cnt;

    timer_display #(
        .CLK_F(1000),
        .BLINK_HZ(10),
        .BLANK_LEAD_ZERO(1'b1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sec_in(sec_in),
        .min_in(min_in),
        .timer_end(timer_end),
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        min_in    = 6'd1;
        sec_in    = 6'd0;
        timer_end = 1'b0;
        #23;
        chk_cnt++;
        if ({hex3, hex2, hex1, hex0, busy} !== {B, B, B, B, 1'b0}) begin
            $display("FAIL reset_state: hex=%h %h %h %h busy=%b, want all 7f busy=0",
                     hex3, hex2, hex1, hex0, busy);
        end else pass_cnt++;
    endtask

    task automatic test_first_conversion();
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk_cnt++;
            if ({busy, hex3, hex2, hex1, hex0} !== {1'b1, B, B, B, B}) begin
                $display("FAIL first_busy edge %0d: busy=%b hex=%h %h %h %h, want busy=1 all 7f",
                         i, busy, hex3, hex2, hex1, hex0);
            end else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({busy, hex3, hex2, hex1, hex0} !== {1'b0, B, D1, D0, D0}) begin
            $display("FAIL first_result: busy=%b hex=%h %h %h %h, want busy=0 %h %h %h %h",
                     busy, hex3, hex2, hex1, hex0, B, D1, D0, D0);
        end else pass_cnt++;
    endtask

    task automatic test_latency_59();
        sec_in = 6'd59;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_cnt++;
            if ({hex2, hex1, hex0} !== {D1, D0, D0}) begin
                $display("FAIL lat59_hold edge %0d: hex2..0=%h %h %h, want %h %h %h",
                         i, hex2, hex1, hex0, D1, D0, D0);
            end else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({busy, hex3, hex2, hex1, hex0} !== {1'b0, B, D1, D5, D9}) begin
            $display("FAIL lat59_result: busy=%b hex=%h %h %h %h, want 0 %h %h %h %h",
                     busy, hex3, hex2, hex1, hex0, B, D1, D5, D9);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        sec_in = 6'd58;
        tick();
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_start: busy=%b want 1", busy);
        else pass_cnt++;
        tick();
        tick();
        sec_in = 6'd57;
        for (int i = 0; i < 5; i++) tick();
        chk_cnt++;
        if ({busy, hex1, hex0} !== {1'b0, D5, D8}) begin
            $display("FAIL b2b_first: busy=%b hex1=%h hex0=%h, want 0 %h %h", busy, hex1, hex0, D5, D8);
        end else pass_cnt++;
        tick();
        chk_cnt++;
        if ({busy, hex0} !== {1'b1, D8}) begin
            $display("FAIL b2b_restart: busy=%b hex0=%h, want 1 %h", busy, hex0, D8);
        end else pass_cnt++;
        for (int i = 0; i < 7; i++) tick();
        chk_cnt++;
        if ({busy, hex1, hex0} !== {1'b0, D5, D7}) begin
            $display("FAIL b2b_second: busy=%b hex1=%h hex0=%h, want 0 %h %h", busy, hex1, hex0, D5, D7);
        end else pass_cnt++;
    endtask

    task automatic test_max_values();
        min_in = 6'd63;
        sec_in = 6'd63;
        for (int i = 0; i < 8; i++) tick();
        chk_cnt++;
        if ({hex3, hex2, hex1, hex0} !== {D6, D3, D6, D3}) begin
            $display("FAIL max63: hex=%h %h %h %h, want %h %h %h %h",
                     hex3, hex2, hex1, hex0, D6, D3, D6, D3);
        end else pass_cnt++;
        min_in = 6'd10;
        sec_in = 6'd5;
        for (int i = 0; i < 8; i++) tick();
        chk_cnt++;
        if ({hex3, hex2, hex1, hex0} !== {D1, D0, D0, D5}) begin
            $display("FAIL mm10_ss05: hex=%h %h %h %h, want %h %h %h %h",
                     hex3, hex2, hex1, hex0, D1, D0, D0, D5);
        end else pass_cnt++;
    endtask

    task automatic test_blink();
        logic [13:0] exp;
        timer_end = 1'b1;
        for (int i = 0; i < 175; i++) begin
            @(negedge clock);
            exp = (((i / 50) % 2) == 1) ? {B, B} : {D1, D5};
            chk_cnt++;
            if ({hex3, hex0} !== exp) begin
                $display("FAIL blink cycle %0d: hex3/hex0=%h/%h, want %h/%h",
                         i, hex3, hex0, exp[13:7], exp[6:0]);
            end else pass_cnt++;
        end
        timer_end = 1'b0;
        #1;
        chk_cnt++;
        if (hex0 !== B) $display("FAIL blink_hold_before_edge: hex0=%h want %h", hex0, B);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({hex3, hex0} !== {D1, D5}) begin
            $display("FAIL blink_stop: hex3/hex0=%h/%h, want %h/%h", hex3, hex0, D1, D5);
        end else pass_cnt++;
        for (int i = 0; i < 60; i++) tick();
        chk_cnt++;
        if (hex0 !== D5) $display("FAIL blink_stays_off: hex0=%h want %h", hex0, D5);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        min_in = 6'd2;
        sec_in = 6'd34;
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, hex3, hex2, hex1, hex0} !== {1'b0, B, B, B, B}) begin
            $display("FAIL abort_async: busy=%b hex=%h %h %h %h, want 0 all 7f",
                     busy, hex3, hex2, hex1, hex0);
        end else pass_cnt++;
        min_in = 6'd7;
        sec_in = 6'd48;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_cnt++;
            if ({busy, hex0} !== {1'b1, B}) begin
                $display("FAIL abort_reconv edge %0d: busy=%b hex0=%h, want 1 %h", i + 1, busy, hex0, B);
            end else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({busy, hex3, hex2, hex1, hex0} !== {1'b0, B, D7, D4, D8}) begin
            $display("FAIL abort_result: busy=%b hex=%h %h %h %h, want 0 %h %h %h %h",
                     busy, hex3, hex2, hex1, hex0, B, D7, D4, D8);
        end else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_first_conversion();
        test_latency_59();
        test_back_to_back();
        test_max_values();
        test_blink();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
